// File: rtl/pkt_payload_filter.sv
// Packet payload filter: decodes {parity, flags, addr}, drops failing beats, queues passing ones in a show-ahead FIFO.
// Define PKT_PAYLOAD_FILTER_PARITY_CHK_EN to include the even-parity check and the par_err pulse.
module pkt_payload_filter #(
    parameter int PARITY  = 1,
    parameter int FLAGS   = 12,
    parameter int ADDR    = 20,
    parameter int PAYLOAD = 32,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PARITY+FLAGS+ADDR-1:0] pkt_ctl_data,
    input  logic [PAYLOAD-1:0]        pkt_payload_in,
    input  logic [ADDR-1:0]           cfg_addr,
    input  logic [ADDR-1:0]           cfg_addr_mask,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PAYLOAD-1:0]        pkt_payload_out,
    output logic [FLAGS-1:0]          out_flags,
    output logic [CNT_W-1:0]          pass_cnt,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      par_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = PAYLOAD + FLAGS;

    logic [ADDR-1:0]  addr;
    logic [FLAGS-1:0] flags;
    logic             par_ok;
    logic             pass;
    logic             accept;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [EW-1:0]    mem [DEPTH];

    assign addr  = pkt_ctl_data[ADDR-1:0];
    assign flags = pkt_ctl_data[ADDR +: FLAGS];

`ifdef PKT_PAYLOAD_FILTER_PARITY_CHK_EN
    // Only the lowest parity bit is checked; even parity over flags, addr and payload.
    assign par_ok = pkt_ctl_data[ADDR+FLAGS] == ^{flags, addr, pkt_payload_in};

    always_ff @(posedge clk) begin
        if (rst) par_err <= 1'b0;
        else     par_err <= accept && !par_ok;
    end
`else
    assign par_ok  = 1'b1;
    assign par_err = 1'b0;
`endif

    assign pass   = (pkt_ctl_data != '0) && (((addr ^ cfg_addr) & cfg_addr_mask) == '0) && par_ok;
    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept = in_valid && in_ready;
    assign push   = accept && pass;
    assign pop    = out_valid && out_ready;

    assign {pkt_payload_out, out_flags} = mem[rptr[AW-1:0]];

    // Storage is cleared on reset so the head reads zero until the first write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wptr[AW-1:0]] <= {pkt_payload_in, flags};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
        end else if (accept) begin
            if (pass && pass_cnt != '1)  pass_cnt <= pass_cnt + CNT_W'(1);
            if (!pass && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pkt_payload_filter.sv
// Randomized + directed bench for pkt_payload_filter against a queue-based reference model.
module tb_pkt_payload_filter;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [32:0] pkt_ctl_data = '0;
    logic [31:0] pkt_payload_in = '0;
    logic [19:0] cfg_addr = '0;
    logic [19:0] cfg_addr_mask = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] pkt_payload_out;
    logic [11:0] out_flags;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic        par_err;

    pkt_payload_filter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pkt_ctl_data(pkt_ctl_data), .pkt_payload_in(pkt_payload_in),
        .cfg_addr(cfg_addr), .cfg_addr_mask(cfg_addr_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .pkt_payload_out(pkt_payload_out), .out_flags(out_flags),
        .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .par_err(par_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {payload, flags}, plain saturating counts.
    typedef struct packed { logic [31:0] pl; logic [11:0] fl; } ent_t;
    ent_t m_q[$];
    int   m_pass, m_drop;
    bit   m_perr, m_fresh, mon_en = 0;

    function automatic logic even_par(input logic [11:0] f, input logic [19:0] a, input logic [31:0] p);
        return ^{f, a, p};
    endfunction

    function automatic logic [32:0] mk_ctl(input logic [11:0] f, input logic [19:0] a,
                                           input logic [31:0] p, input bit good);
        logic pb;
        pb = even_par(f, a, p);
        return {good ? pb : ~pb, f, a};
    endfunction

    always @(posedge clk) begin
        bit acc, ok, pbad;
        logic [19:0] a;
        logic [11:0] f;
        if (rst) begin
            m_q.delete();
            m_pass = 0; m_drop = 0; m_perr = 0; m_fresh = 1;
        end else begin
            acc = in_valid && (m_q.size() < DEPTH);
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            a = pkt_ctl_data[19:0];
            f = pkt_ctl_data[31:20];
            pbad = pkt_ctl_data[32] != even_par(f, a, pkt_payload_in);
`ifdef PKT_PAYLOAD_FILTER_PARITY_CHK_EN
            ok = (pkt_ctl_data != 0) && (((a ^ cfg_addr) & cfg_addr_mask) == 0) && !pbad;
            m_perr = acc && pbad;
`else
            ok = (pkt_ctl_data != 0) && (((a ^ cfg_addr) & cfg_addr_mask) == 0);
            m_perr = 0;
`endif
            if (acc && ok) begin
                m_q.push_back('{pl: pkt_payload_in, fl: f});
                m_fresh = 0;
                if (m_pass < CMAX) m_pass++;
            end else if (acc) begin
                if (m_drop < CMAX) m_drop++;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", in_ready, m_q.size() < DEPTH);
            chk("out_valid", out_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("head_payload", pkt_payload_out, m_q[0].pl);
                chk("head_flags", out_flags, m_q[0].fl);
            end else if (m_fresh) begin
                chk("rst_payload", pkt_payload_out, 0);
                chk("rst_flags", out_flags, 0);
            end
            chk("pass_cnt", pass_cnt, m_pass);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("par_err", par_err, m_perr);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; out_ready = 0;
        step(); step();
        rst = 0;
    endtask

    task automatic beat(input logic [11:0] f, input logic [19:0] a, input logic [31:0] p, input bit good);
        pkt_ctl_data = mk_ctl(f, a, p, good);
        pkt_payload_in = p;
        in_valid = 1;
    endtask

    logic [31:0] got[$];
    int k;
    bit acc;

    initial begin
        do_reset();
        mon_en = 1;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_payload", pkt_payload_out, 0);
        chk("reset_cnts", {pass_cnt, drop_cnt, par_err}, 0);

        // single pass
        step();
        beat(12'h001, 20'h00010, 32'hDEADBEEF, 1);
        step(); in_valid = 0;
        @(negedge clk);
        chk("single_valid", out_valid, 1);
        chk("single_payload", pkt_payload_out, 32'hDEADBEEF);
        chk("single_flags", out_flags, 12'h001);
        chk("single_pass", pass_cnt, 1);
        step(); out_ready = 1; step(); out_ready = 0;

        // zero control word
        do_reset();
        pkt_ctl_data = '0; pkt_payload_in = 32'h12345678; in_valid = 1;
        step(); in_valid = 0;
        @(negedge clk);
        chk("zero_drop", drop_cnt, 1);
        chk("zero_valid", out_valid, 0);
        chk("zero_perr", par_err, 0);

        // address filter
        step(); do_reset();
        cfg_addr = 20'hABC00; cfg_addr_mask = 20'hFFF00;
        beat(12'h005, 20'hABC7F, 32'h00000001, 1); step();
        beat(12'h006, 20'hABD00, 32'h00000002, 1); step();
        in_valid = 0;
        @(negedge clk);
        chk("addr_pass", pass_cnt, 1);
        chk("addr_drop", drop_cnt, 1);
        chk("addr_head", pkt_payload_out, 32'h1);
        cfg_addr = '0; cfg_addr_mask = '0;

        // parity error
        step(); do_reset();
        beat(12'h003, 20'h00007, 32'hCAFEF00D, 0);
        step(); in_valid = 0;
        @(negedge clk);
`ifdef PKT_PAYLOAD_FILTER_PARITY_CHK_EN
        chk("par_pulse", par_err, 1);
        chk("par_drop", drop_cnt, 1);
        chk("par_valid", out_valid, 0);
`else
        chk("par_off_perr", par_err, 0);
        chk("par_off_pass", pass_cnt, 1);
`endif
        step(); @(negedge clk);
        chk("par_pulse_end", par_err, 0);

        // backpressure and full
        step(); do_reset();
        for (k = 0; k < 4; k++) begin
            beat(12'(k + 1), 20'h0, 32'hA0 + k, 1);
            step();
        end
        beat(12'(k + 1), 20'h0, 32'hA0 + k, 1);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        step();
        out_ready = 1;
        got.delete();
        for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
            in_valid = (k < 6);
            if (k < 6) beat(12'(k + 1), 20'h0, 32'hA0 + k, 1);
            acc = in_valid && in_ready;
            @(negedge clk);
            if (out_valid) got.push_back(pkt_payload_out);
            step();
            if (acc) k++;
        end
        in_valid = 0; out_ready = 0;
        chk("drain_count", got.size(), 6);
        foreach (got[i]) chk("drain_order", got[i], 32'hA0 + i);

        // counter saturation, then reset with entries queued
        do_reset();
        pkt_ctl_data = '0; in_valid = 1;
        for (int i = 0; i < 20; i++) step();
        in_valid = 0;
        @(negedge clk);
        chk("sat_drop", drop_cnt, 15);
        step();
        beat(12'h00A, 20'h1, 32'h55, 1); step();
        beat(12'h00B, 20'h2, 32'h66, 1); step();
        in_valid = 0; rst = 1;
        step(); rst = 0;
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        chk("flush_cnts", {pass_cnt, drop_cnt}, 0);

        // randomized traffic, model-checked every cycle
        step();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            logic [19:0] a;
            if (cyc % 500 == 0) begin
                cfg_addr = 20'($urandom);
                case ($urandom_range(0, 2))
                    0: cfg_addr_mask = '0;
                    1: cfg_addr_mask = 20'hFFF00;
                    default: cfg_addr_mask = 20'($urandom) & 20'($urandom);
                endcase
            end
            rst = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 9);
            a = (r < 6) ? ((cfg_addr & cfg_addr_mask) | (20'($urandom) & ~cfg_addr_mask)) : 20'($urandom);
            beat(12'($urandom), a, $urandom, $urandom_range(0, 3) != 0);
            if (r == 0) pkt_ctl_data = '0;
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        rst = 0; in_valid = 0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
